// File: rtl/servo_ctrl_pkg.sv
// Shared constants and helpers for the servo slew controller: state codes, duty width,
// frame divider arithmetic and duty clamping.
package servo_ctrl_pkg;

  localparam int unsigned DUTY_W = 8;
  localparam int unsigned DIFF_W = DUTY_W + 1;
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RAMP = 2'd1;
  localparam logic [STATE_W-1:0] ST_HOLD = 2'd2;

  // Clocks per servo frame; degenerate rates collapse to a tick every cycle.
  function automatic int unsigned frame_div(input int unsigned clk_hz,
                                            input int unsigned frame_hz);
    int unsigned div;
    div = (frame_hz == 0) ? 1 : clk_hz / frame_hz;
    return (div == 0) ? 1 : div;
  endfunction

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] v,
                                                   input logic [DUTY_W-1:0] lo,
                                                   input logic [DUTY_W-1:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/servo_frame_tick.sv
// Free-running frame divider: counts 0..FRAME_DIV-1 and pulses frame_tick while the
// count sits at its last value.
module servo_frame_tick #(
  parameter int unsigned FRAME_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic frame_tick
);

  localparam int unsigned CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Tick is registered from the next count so it lines up with count == last.
  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= (FRAME_DIV == 1);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/servo_slew_ctrl.sv
// Servo position sequencer: ramps dutty toward each accepted target one STEP per frame,
// then settles for HOLD_FRAMES frames. Define SERVO_LIMIT_EN to clamp targets to [MIN_DUTY, MAX_DUTY].
module servo_slew_ctrl
  import servo_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned FRAME_HZ    = 50,
  parameter int unsigned STEP        = 1,
  parameter int unsigned HOLD_FRAMES = 10,
  parameter int unsigned INIT_DUTY   = 128,
  parameter int unsigned MIN_DUTY    = 0,
  parameter int unsigned MAX_DUTY    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [DUTY_W-1:0] cmd_pos,
  output logic              cmd_ready,
  output logic [DUTY_W-1:0] dutty,
  output logic              busy,
  output logic              done,
  output logic              frame_tick
);

`ifdef SERVO_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam int unsigned       FRAME_DIV = frame_div(CLK_HZ, FRAME_HZ);
  localparam logic [DUTY_W-1:0] MIN_L     = DUTY_W'(MIN_DUTY);
  localparam logic [DUTY_W-1:0] MAX_L     = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] INIT_L    = LIMIT_EN ? clamp_duty(DUTY_W'(INIT_DUTY), MIN_L, MAX_L)
                                                     : DUTY_W'(INIT_DUTY);
  localparam logic [DUTY_W-1:0] STEP_L    = DUTY_W'(STEP);
  localparam logic [DIFF_W-1:0] STEP_D    = DIFF_W'(STEP);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES);

  logic [STATE_W-1:0] state_q, state_d;
  logic [DUTY_W-1:0]  dutty_q, dutty_d;
  logic [DUTY_W-1:0]  target_q, target_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               tick_c;
  logic [DUTY_W-1:0]  pos_lim_c;
  logic [DIFF_W-1:0]  diff_c;

  servo_frame_tick #(
    .FRAME_DIV(FRAME_DIV)
  ) u_frame_tick (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (tick_c)
  );

  assign pos_lim_c = LIMIT_EN ? clamp_duty(cmd_pos, MIN_L, MAX_L) : cmd_pos;

  // Distance to target, one bit wider so the magnitude never wraps.
  assign diff_c = (target_q > dutty_q) ? ({1'b0, target_q} - {1'b0, dutty_q})
                                       : ({1'b0, dutty_q} - {1'b0, target_q});

  always_comb begin
    state_d  = state_q;
    dutty_d  = dutty_q;
    target_d = target_q;
    hold_d   = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          target_d = pos_lim_c;
          state_d  = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (tick_c) begin
          if (diff_c <= STEP_D) begin
            dutty_d = target_q;
            hold_d  = '0;
            state_d = ST_HOLD;
          end else if (target_q > dutty_q) begin
            dutty_d = dutty_q + STEP_L;
          end else begin
            dutty_d = dutty_q - STEP_L;
          end
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_IDLE;
        end else if (tick_c) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flags are registered from the next state so they track state_q exactly.
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_HOLD) && (hold_d == HOLD_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dutty_q  <= INIT_L;
      target_q <= INIT_L;
      hold_q   <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dutty_q  <= dutty_d;
      target_q <= target_d;
      hold_q   <= hold_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign dutty      = dutty_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign frame_tick = tick_c;

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Bench for servo_slew_ctrl: two instances (STEP=1/HOLD=2 and STEP=3/HOLD=0) checked every
// cycle against a frame-level model, plus directed literal expectations.
module tb_servo_slew_ctrl;

`ifdef SERVO_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  localparam int FDIV = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       va, vb;
  logic [7:0] pa, pb;
  logic       rdy_a, busy_a, done_a, tick_a;
  logic       rdy_b, busy_b, done_b, tick_b;
  logic [7:0] d_a, d_b;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  servo_slew_ctrl #(
    .CLK_HZ(1000), .FRAME_HZ(100), .STEP(1), .HOLD_FRAMES(2),
    .INIT_DUTY(128), .MIN_DUTY(0), .MAX_DUTY(255)
  ) dut_a (
    .clk(clk), .rst(rst), .cmd_valid(va), .cmd_pos(pa), .cmd_ready(rdy_a),
    .dutty(d_a), .busy(busy_a), .done(done_a), .frame_tick(tick_a)
  );

  servo_slew_ctrl #(
    .CLK_HZ(1000), .FRAME_HZ(100), .STEP(3), .HOLD_FRAMES(0),
    .INIT_DUTY(128), .MIN_DUTY(64), .MAX_DUTY(192)
  ) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(vb), .cmd_pos(pb), .cmd_ready(rdy_b),
    .dutty(d_b), .busy(busy_b), .done(done_b), .frame_tick(tick_b)
  );

  function automatic int dut_d(input int k);
    return (k == 0) ? int'(d_a) : int'(d_b);
  endfunction
  function automatic int dut_rdy(input int k);
    return (k == 0) ? int'(rdy_a) : int'(rdy_b);
  endfunction
  function automatic int dut_busy(input int k);
    return (k == 0) ? int'(busy_a) : int'(busy_b);
  endfunction
  function automatic int dut_done(input int k);
    return (k == 0) ? int'(done_a) : int'(done_b);
  endfunction
  function automatic int dut_tick(input int k);
    return (k == 0) ? int'(tick_a) : int'(tick_b);
  endfunction

  task automatic chk(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[%0d] t=%0t actual=%0d required=%0d", nm, k, $time, act, exp);
    end
  endtask

  // Frame-level model: mode 0 idle, 1 moving, 2 settling.
  int m_cnt[2], m_mode[2], m_d[2], m_t[2], m_hold[2];

  function automatic int m_step(input int k);
    return (k == 0) ? 1 : 3;
  endfunction
  function automatic int m_hf(input int k);
    return (k == 0) ? 2 : 0;
  endfunction
  function automatic int m_lim(input int k, input int p);
    if (k == 1 && LIMIT) return (p < 64) ? 64 : ((p > 192) ? 192 : p);
    return p;
  endfunction

  task automatic model_step(input int k);
    int  v, p, diff, st;
    bit  tick;
    v  = (k == 0) ? int'(va) : int'(vb);
    p  = (k == 0) ? int'(pa) : int'(pb);
    st = m_step(k);
    if (rst) begin
      m_cnt[k] = 0; m_mode[k] = 0; m_d[k] = 128; m_t[k] = 128; m_hold[k] = 0;
    end else begin
      tick     = (m_cnt[k] == FDIV - 1);
      m_cnt[k] = (m_cnt[k] + 1) % FDIV;
      case (m_mode[k])
        0: if (v != 0) begin m_t[k] = m_lim(k, p); m_mode[k] = 1; end
        1: if (tick) begin
          diff = (m_t[k] > m_d[k]) ? m_t[k] - m_d[k] : m_d[k] - m_t[k];
          if (diff <= st) begin
            m_d[k] = m_t[k]; m_hold[k] = 0; m_mode[k] = 2;
          end else if (m_t[k] > m_d[k]) m_d[k] = m_d[k] + st;
          else m_d[k] = m_d[k] - st;
        end
        default: begin
          if (m_hold[k] == m_hf(k)) m_mode[k] = 0;
          else if (tick) m_hold[k] = m_hold[k] + 1;
        end
      endcase
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  always begin
    @(posedge clk);
    #1;
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("dutty", k, dut_d(k), m_d[k]);
        chk("cmd_ready", k, dut_rdy(k), int'(m_mode[k] == 0));
        chk("busy", k, dut_busy(k), int'(m_mode[k] != 0));
        chk("done", k, dut_done(k), int'(m_mode[k] == 2 && m_hold[k] == m_hf(k)));
        chk("frame_tick", k, dut_tick(k), int'(m_cnt[k] == FDIV - 1));
      end
    end
  end

  task automatic set_in(input int k, input logic v, input int pos);
    if (k == 0) begin va = v; pa = 8'(pos); end
    else begin vb = v; pb = 8'(pos); end
  endtask

  task automatic send(input int k, input int pos);
    int n = 0;
    @(negedge clk);
    set_in(k, 1'b1, pos);
    while (dut_rdy(k) == 0 && n < 500) begin @(negedge clk); n++; end
    chk("accept", k, dut_rdy(k), 1);
    @(negedge clk);
    set_in(k, 1'b0, pos);
  endtask

  int seq[$];
  int gap;
  task automatic collect(input int k, input int budget);
    int n = 0, prev, last_chg = 0;
    bit got = 1'b0;
    seq.delete();
    prev = dut_d(k);
    while (n < budget && !got) begin
      @(posedge clk); #1; n++;
      if (dut_d(k) != prev) begin prev = dut_d(k); seq.push_back(prev); last_chg = n; end
      if (dut_done(k) != 0) got = 1'b1;
    end
    chk("done_seen", k, int'(got), 1);
    gap = n - last_chg;
  endtask

  task automatic wait_dutty(input int k, input int val, input int budget);
    int n = 0;
    while (dut_d(k) != val && n < budget) begin @(posedge clk); #1; n++; end
    chk("reach_dutty", k, dut_d(k), val);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (tick_a == 1'b0 && n < 50);
  endtask

  initial begin
    int n;
    rst = 1'b1; va = 1'b0; vb = 1'b0; pa = '0; pb = '0;
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_dutty", 0, dut_d(0), 128);
    chk("rst_ready", 0, dut_rdy(0), 1);
    chk("rst_busy", 0, dut_busy(0), 0);
    chk("rst_done", 0, dut_done(0), 0);
    chk("rst_dutty", 1, dut_d(1), 128);
    rst = 1'b0;

    wait_tick(n);
    chk("first_tick_delay", 0, n, 9);
    wait_tick(n);
    chk("tick_period", 0, n, 10);

    // Slow ramp up by one per frame, two settle frames.
    send(0, 132);
    collect(0, 200);
    chk("ramp_len", 0, seq.size(), 4);
    for (int i = 0; i < 4; i++) chk("ramp_val", 0, (i < seq.size()) ? seq[i] : -1, 129 + i);
    chk("done_gap", 0, gap, 20);
    chk("done_ready_excl", 0, dut_rdy(0), 0);
    @(posedge clk); #1;
    chk("ready_after_done", 0, dut_rdy(0), 1);

    // Backpressure: second command waits until the block is idle again.
    send(0, 140);
    @(negedge clk);
    set_in(0, 1'b1, 0);
    n = 0;
    while (done_a == 1'b0 && n < 300) begin @(posedge clk); #1; n++; end
    chk("bp_done_seen", 0, int'(done_a), 1);
    chk("bp_dutty_at_done", 0, dut_d(0), 140);
    chk("bp_ready_at_done", 0, dut_rdy(0), 0);
    @(posedge clk); #1;
    chk("bp_ready_next", 0, dut_rdy(0), 1);
    @(posedge clk); #1;
    chk("bp_accepted", 0, dut_busy(0), 1);
    @(negedge clk);
    set_in(0, 1'b0, 0);
    wait_dutty(0, 139, 30);
    wait_dutty(0, 135, 60);

    // Reset mid-ramp.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_dutty", 0, dut_d(0), 128);
    chk("midrst_ready", 0, dut_rdy(0), 1);
    chk("midrst_busy", 0, dut_busy(0), 0);
    @(negedge clk);
    rst = 1'b0;

    // Target equals current duty: straight to settle, zero settle frames.
    send(1, 128);
    collect(1, 100);
    chk("same_no_change", 1, seq.size(), 0);
    chk("same_dutty", 1, dut_d(1), 128);

    // Step of three with clamped final step.
    send(1, 120);
    collect(1, 100);
    chk("down_len", 1, seq.size(), 3);
    chk("down_v0", 1, (seq.size() > 0) ? seq[0] : -1, 125);
    chk("down_v1", 1, (seq.size() > 1) ? seq[1] : -1, 122);
    chk("down_v2", 1, (seq.size() > 2) ? seq[2] : -1, 120);

    // Out-of-range target: clamped only with the limit feature.
    send(1, 250);
    collect(1, 700);
    chk("limit_final", 1, dut_d(1), LIMIT ? 192 : 250);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
